// File: rtl/ahb_arb_pkg.sv
// Shared AHB code points, arbiter state encoding and burst-length decoding
// for the round-robin AHB arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        ST_PARK,
        ST_GRANT,
        ST_BURST,
        ST_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [3:0] load;
        logic       isUndef;
    } burst_info_t;

    // Beat counter load is burst length minus one; INCR has no known length.
    function automatic burst_info_t burst_beats(input logic [2:0] hburst);
        burst_info_t info;
        info.load    = 4'd0;
        info.isUndef = 1'b0;
        case (hburst)
            BURST_INCR:                 info.isUndef = 1'b1;
            BURST_WRAP4,  BURST_INCR4:  info.load    = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  info.load    = 4'd7;
            BURST_WRAP16, BURST_INCR16: info.load    = 4'd15;
            default:                    info.load    = 4'd0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first eligible master after last_i,
// wrapping, with last_i itself considered last.
module ahb_rr_picker #(
    parameter int NUM_MST = 4,
    parameter int MST_W   = 2
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [NUM_MST-1:0] mask_i,
    input  logic [MST_W-1:0]   last_i,
    output logic [MST_W-1:0]   next_o,
    output logic               found_o
);

    logic [MST_W-1:0] cand;

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            cand = MST_W'((int'(last_i) + i) % NUM_MST);
            if (!found_o && req_i[cand] && !mask_i[cand]) begin
                next_o  = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: grants, address-phase HMASTER/HMASTLOCK, burst
// tracking, locked transfers and SPLIT masking released through HSPLIT.
module ahb_arbiter #(
    parameter int NUM_MST = 4,
    parameter int MST_W   = 2,
    parameter int DEF_MST = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MST-1:0] mst_hbusreq,
    input  logic [NUM_MST-1:0] mst_hlock,
    input  logic [1:0]         ahbm_HTRANS,
    input  logic [2:0]         ahbm_HBURST,
    input  logic               ahbs_HREADY,
    input  logic [1:0]         ahbs_HRESP,
    input  logic [15:0]        ahbs_arb_HSPLIT,
    output logic [NUM_MST-1:0] arb_HGRANT,
    output logic [3:0]         arb_ahbs_HMASTER,
    output logic               arb_ahbs_HMASTLOCK
);
    import ahb_arb_pkg::*;

    localparam logic [MST_W-1:0] DEF_IDX = MST_W'(DEF_MST);

    arb_state_e         state_q, state_d;
    logic [MST_W-1:0]   owner_q, owner_d, hmaster_q, hmaster_d, pickIdx;
    logic               hmastlock_q, hmastlock_d, forceArb_q, forceArb_d;
    logic               undef_q, undef_d, pickFound;
    logic [3:0]         beatCnt_q, beatCnt_d;
    logic [NUM_MST-1:0] splitMask_q, splitMask_d, splitSet, splitClr;
    logic [15:0]        unusedHsplit;
    burst_info_t        burst;
    logic isIdle, isNonseq, isSeq, ownerReq, ownerLock;
    logic lastBeat, undefDone, arbPoint;

    assign burst        = burst_beats(ahbm_HBURST);
    assign isIdle       = (ahbm_HTRANS == TRANS_IDLE);
    assign isNonseq     = (ahbm_HTRANS == TRANS_NONSEQ);
    assign isSeq        = (ahbm_HTRANS == TRANS_SEQ);
    assign ownerReq     = mst_hbusreq[owner_q];
    assign ownerLock    = mst_hlock[owner_q];
    assign unusedHsplit = ahbs_arb_HSPLIT;
    assign splitClr     = ahbs_arb_HSPLIT[NUM_MST-1:0];
    assign splitSet     = (!ahbs_HREADY && ahbs_HRESP == RESP_SPLIT)
                          ? (NUM_MST'(1) << hmaster_q) : '0;

    assign lastBeat  = (isSeq && beatCnt_q == 4'd1 && !undef_q)
                     || (isNonseq && burst.load == 4'd0 && !burst.isUndef);
    assign undefDone = undef_q && (state_q == ST_BURST) && !ownerReq;

    // A locked owner is only released by an IDLE with hlock dropped; a
    // SPLIT/RETRY forces hand-over on the second response cycle regardless.
    assign arbPoint = (forceArb_q && ahbs_HREADY)
                    || (ahbs_HREADY && state_q != ST_LOCKED && (isIdle || lastBeat || undefDone))
                    || (ahbs_HREADY && state_q == ST_LOCKED && isIdle && !ownerLock);

    ahb_rr_picker #(
        .NUM_MST (NUM_MST),
        .MST_W   (MST_W)
    ) u_picker (
        .req_i   (mst_hbusreq),
        .mask_i  (splitMask_q),
        .last_i  (owner_q),
        .next_o  (pickIdx),
        .found_o (pickFound)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        beatCnt_d   = beatCnt_q;
        undef_d     = undef_q;
        forceArb_d  = !ahbs_HREADY && (ahbs_HRESP == RESP_RETRY || ahbs_HRESP == RESP_SPLIT);
        // Set beats clear so a release racing a new SPLIT cannot lose it.
        splitMask_d = (splitMask_q & ~splitClr) | splitSet;

        if (ahbs_HREADY) begin
            hmaster_d   = owner_q;
            hmastlock_d = ownerLock;
            if (isNonseq) begin
                beatCnt_d = burst.load;
                undef_d   = burst.isUndef;
            end else if (isSeq && beatCnt_q != 4'd0) begin
                beatCnt_d = beatCnt_q - 4'd1;
            end
        end

        if (arbPoint) begin
            if (pickFound) begin
                owner_d = pickIdx;
                state_d = mst_hlock[pickIdx] ? ST_LOCKED : ST_GRANT;
            end else begin
                owner_d = DEF_IDX;
                state_d = ST_PARK;
            end
        end else begin
            case (state_q)
                ST_PARK, ST_GRANT: begin
                    if (state_q == ST_GRANT && ownerLock)
                        state_d = ST_LOCKED;
                    else if (ahbs_HREADY && isNonseq && (burst.load != 4'd0 || burst.isUndef))
                        state_d = ST_BURST;
                end
                ST_BURST:  if (ownerLock) state_d = ST_LOCKED;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PARK;
            owner_q     <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            beatCnt_q   <= 4'd0;
            undef_q     <= 1'b0;
            forceArb_q  <= 1'b0;
            splitMask_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            beatCnt_q   <= beatCnt_d;
            undef_q     <= undef_d;
            forceArb_q  <= forceArb_d;
            splitMask_q <= splitMask_d;
        end
    end

    assign arb_HGRANT         = NUM_MST'(1) << owner_q;
    assign arb_ahbs_HMASTER   = 4'(hmaster_q);
    assign arb_ahbs_HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round-robin bursts, locking,
// SPLIT masking/release, wait states and mid-burst reset.
module tb_ahb_arbiter;
    import ahb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mst_hbusreq, mst_hlock, arb_HGRANT, arb_ahbs_HMASTER;
    logic [1:0]  ahbm_HTRANS, ahbs_HRESP;
    logic [2:0]  ahbm_HBURST;
    logic        ahbs_HREADY, arb_ahbs_HMASTLOCK;
    logic [15:0] ahbs_arb_HSPLIT;
    int checks = 0;
    int errors = 0;

    ahb_arbiter #(.NUM_MST(4), .MST_W(2), .DEF_MST(0)) dut (
        .clk                (clk),
        .rst                (rst),
        .mst_hbusreq        (mst_hbusreq),
        .mst_hlock          (mst_hlock),
        .ahbm_HTRANS        (ahbm_HTRANS),
        .ahbm_HBURST        (ahbm_HBURST),
        .ahbs_HREADY        (ahbs_HREADY),
        .ahbs_HRESP         (ahbs_HRESP),
        .ahbs_arb_HSPLIT    (ahbs_arb_HSPLIT),
        .arb_HGRANT         (arb_HGRANT),
        .arb_ahbs_HMASTER   (arb_ahbs_HMASTER),
        .arb_ahbs_HMASTLOCK (arb_ahbs_HMASTLOCK)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] trans, input logic [2:0] hburst,
                         input logic ready, input logic [1:0] resp);
        ahbm_HTRANS = trans;
        ahbm_HBURST = hburst;
        ahbs_HREADY = ready;
        ahbs_HRESP  = resp;
    endtask

    task automatic test_reset();
        rst = 1'b1; mst_hbusreq = 4'b0000; mst_hlock = 4'b0000; ahbs_arb_HSPLIT = 16'h0000;
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY);
        tick(); tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL reset_grant got %b want 0001", arb_HGRANT); end
        checks++; if (arb_ahbs_HMASTER !== 4'd0) begin errors++; $display("[TB] FAIL reset_hmaster got %0d want 0", arb_ahbs_HMASTER); end
        checks++; if (arb_ahbs_HMASTLOCK !== 1'b0) begin errors++; $display("[TB] FAIL reset_lock got %b want 0", arb_ahbs_HMASTLOCK); end
        rst = 1'b0;
        tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL park_grant got %b want 0001", arb_HGRANT); end
        checks++; if (dut.state_q !== ST_PARK) begin errors++; $display("[TB] FAIL park_state got %0d want %0d", dut.state_q, ST_PARK); end
    endtask

    task automatic test_burst();
        mst_hbusreq = 4'b0110;
        tick();
        checks++; if (arb_HGRANT !== 4'b0010) begin errors++; $display("[TB] FAIL rr_first got %b want 0010", arb_HGRANT); end
        drive(TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY);
        tick();
        checks++; if (arb_ahbs_HMASTER !== 4'd1) begin errors++; $display("[TB] FAIL incr4_hmaster got %0d want 1", arb_ahbs_HMASTER); end
        drive(TRANS_SEQ, BURST_INCR4, 1'b1, RESP_OKAY);
        for (int i = 2; i <= 3; i++) begin
            tick();
            checks++; if (arb_HGRANT !== 4'b0010) begin errors++; $display("[TB] FAIL incr4_beat%0d got %b want 0010", i, arb_HGRANT); end
        end
        tick();
        checks++; if (arb_HGRANT !== 4'b0100) begin errors++; $display("[TB] FAIL incr4_handover got %b want 0100", arb_HGRANT); end
        checks++; if (arb_ahbs_HMASTER !== 4'd1) begin errors++; $display("[TB] FAIL incr4_hmaster_lag got %0d want 1", arb_ahbs_HMASTER); end
    endtask

    task automatic test_lock();
        mst_hbusreq = 4'b1100; mst_hlock = 4'b0100;
        drive(TRANS_NONSEQ, BURST_INCR8, 1'b1, RESP_OKAY);
        tick();
        checks++; if (arb_ahbs_HMASTER !== 4'd2) begin errors++; $display("[TB] FAIL lock_hmaster got %0d want 2", arb_ahbs_HMASTER); end
        checks++; if (arb_ahbs_HMASTLOCK !== 1'b1) begin errors++; $display("[TB] FAIL lock_mastlock got %b want 1", arb_ahbs_HMASTLOCK); end
        drive(TRANS_SEQ, BURST_INCR8, 1'b1, RESP_OKAY);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++; if (arb_HGRANT !== 4'b0100) begin errors++; $display("[TB] FAIL lock_seq%0d got %b want 0100", i, arb_HGRANT); end
        end
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY);
        tick();
        checks++; if (arb_HGRANT !== 4'b0100) begin errors++; $display("[TB] FAIL lock_idle_held got %b want 0100", arb_HGRANT); end
        mst_hlock = 4'b0000;
        tick();
        checks++; if (arb_HGRANT !== 4'b1000) begin errors++; $display("[TB] FAIL lock_release got %b want 1000", arb_HGRANT); end
        checks++; if (arb_ahbs_HMASTLOCK !== 1'b0) begin errors++; $display("[TB] FAIL lock_drop got %b want 0", arb_ahbs_HMASTLOCK); end
    endtask

    task automatic test_split();
        mst_hbusreq = 4'b0110;
        tick();
        checks++; if (arb_HGRANT !== 4'b0010) begin errors++; $display("[TB] FAIL split_pre got %b want 0010", arb_HGRANT); end
        drive(TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY); tick();
        drive(TRANS_SEQ, BURST_INCR4, 1'b0, RESP_SPLIT); tick();
        checks++; if (arb_ahbs_HMASTER !== 4'd1) begin errors++; $display("[TB] FAIL split_wait_hmaster got %0d want 1", arb_ahbs_HMASTER); end
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_SPLIT); tick();
        checks++; if (arb_HGRANT !== 4'b0100) begin errors++; $display("[TB] FAIL split_move got %b want 0100", arb_HGRANT); end
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY); tick();
        checks++; if (arb_HGRANT !== 4'b0100) begin errors++; $display("[TB] FAIL split_masked_skip got %b want 0100", arb_HGRANT); end
        ahbs_arb_HSPLIT = 16'h0002; tick();
        ahbs_arb_HSPLIT = 16'h0000; tick();
        checks++; if (arb_HGRANT !== 4'b0010) begin errors++; $display("[TB] FAIL split_regain got %b want 0010", arb_HGRANT); end
    endtask

    task automatic test_all_masked();
        drive(TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY); tick();
        drive(TRANS_SEQ, BURST_INCR4, 1'b0, RESP_SPLIT); tick();
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_SPLIT); tick();
        drive(TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY); tick();
        drive(TRANS_SEQ, BURST_INCR4, 1'b0, RESP_SPLIT); tick();
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_SPLIT); tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL allmask_park got %b want 0001", arb_HGRANT); end
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY); tick();
        ahbs_arb_HSPLIT = 16'h0002; tick();
        ahbs_arb_HSPLIT = 16'h0000; tick();
        checks++; if (arb_HGRANT !== 4'b0010) begin errors++; $display("[TB] FAIL allmask_release1 got %b want 0010", arb_HGRANT); end
        drive(TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY); tick();
        ahbs_arb_HSPLIT = 16'h0002;
        drive(TRANS_SEQ, BURST_INCR4, 1'b0, RESP_SPLIT); tick();
        ahbs_arb_HSPLIT = 16'h0000;
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_SPLIT); tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL set_wins got %b want 0001", arb_HGRANT); end
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY); tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL set_wins_hold got %b want 0001", arb_HGRANT); end
        ahbs_arb_HSPLIT = 16'hFFF0; tick(); tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL hsplit_high_ignored got %b want 0001", arb_HGRANT); end
        ahbs_arb_HSPLIT = 16'h0006; tick();
        ahbs_arb_HSPLIT = 16'h0000; tick();
        checks++; if (arb_HGRANT !== 4'b0010) begin errors++; $display("[TB] FAIL allmask_clear got %b want 0010", arb_HGRANT); end
    endtask

    task automatic test_wait_reset();
        drive(TRANS_NONSEQ, BURST_INCR8, 1'b1, RESP_OKAY); tick();
        drive(TRANS_SEQ, BURST_INCR8, 1'b1, RESP_OKAY); tick();
        drive(TRANS_SEQ, BURST_INCR8, 1'b0, RESP_OKAY);
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if (dut.beatCnt_q !== 4'd6) begin errors++; $display("[TB] FAIL wait%0d_beat got %0d want 6", i, dut.beatCnt_q); end
            checks++; if (arb_ahbs_HMASTER !== 4'd1) begin errors++; $display("[TB] FAIL wait%0d_hmaster got %0d want 1", i, arb_ahbs_HMASTER); end
        end
        mst_hlock = 4'b0010;
        drive(TRANS_SEQ, BURST_INCR8, 1'b1, RESP_OKAY); tick();
        checks++; if (dut.beatCnt_q !== 4'd5) begin errors++; $display("[TB] FAIL wait_resume_beat got %0d want 5", dut.beatCnt_q); end
        checks++; if (arb_ahbs_HMASTLOCK !== 1'b1) begin errors++; $display("[TB] FAIL wait_lock got %b want 1", arb_ahbs_HMASTLOCK); end
        rst = 1'b1; tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_grant got %b want 0001", arb_HGRANT); end
        checks++; if (arb_ahbs_HMASTER !== 4'd0) begin errors++; $display("[TB] FAIL midrst_hmaster got %0d want 0", arb_ahbs_HMASTER); end
        checks++; if (arb_ahbs_HMASTLOCK !== 1'b0) begin errors++; $display("[TB] FAIL midrst_lock got %b want 0", arb_ahbs_HMASTLOCK); end
        checks++; if (dut.beatCnt_q !== 4'd0) begin errors++; $display("[TB] FAIL midrst_beat got %0d want 0", dut.beatCnt_q); end
        rst = 1'b0; mst_hbusreq = 4'b0000; mst_hlock = 4'b0000;
        drive(TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY); tick();
        checks++; if (arb_HGRANT !== 4'b0001) begin errors++; $display("[TB] FAIL postrst_grant got %b want 0001", arb_HGRANT); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_lock();
        test_split();
        test_all_masked();
        test_wait_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
